ifetch_queue: RTL and testbench

Instruction fetch stage sitting directly downstream of the PC branch/update stage: it takes the word-addressed PC stream (PC advances by 1 per instruction, branches redirect it), issues reads to a synchronous instruction memory and buffers the returned instructions, each tagged with its PC, in a small in-order FIFO. Decode consumes the FIFO through a valid/ready handshake. A taken branch or unconditional branch arrives as a redirect that flushes all buffered and in-flight instructions and restarts fetch at the new PC.

---
 rtl/ifetch_queue_if.sv | 28 ++
 rtl/ifetch_queue.sv | 101 ++++++++++
 tb/tb_ifetch_queue.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus: PC redirect in, instruction-memory port, decode-side valid/ready.
// master = the fetch queue, slave = its environment (branch unit, imem, decode).
interface ifetch_queue_if #(
    parameter int BITSIZE  = 64,
    parameter int INSTSIZE = 32,
    parameter int IMEM_AW  = 8
);
    logic                redirect;
    logic [BITSIZE-1:0]  redirect_pc;
    logic                imem_req;
    logic [IMEM_AW-1:0]  imem_addr;
    logic [INSTSIZE-1:0] imem_rdata;
    logic                inst_valid;
    logic                inst_ready;
    logic [INSTSIZE-1:0] inst_out;
    logic [BITSIZE-1:0]  inst_pc;
    logic [BITSIZE-1:0]  fetch_pc;

    modport master (
        input  redirect, redirect_pc, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_valid, inst_out, inst_pc, fetch_pc
    );

    modport slave (
        output redirect, redirect_pc, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst_out, inst_pc, fetch_pc
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues reads to a synchronous imem and buffers
// {inst, pc} pairs in an in-order FIFO; a redirect flushes and restarts fetch.
module ifetch_queue #(
    parameter int BITSIZE  = 64,
    parameter int INSTSIZE = 32,
    parameter int DEPTH    = 4,
    parameter int IMEM_AW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_queue_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [INSTSIZE-1:0] inst_mem_q [DEPTH];
    logic [BITSIZE-1:0]  pc_mem_q   [DEPTH];

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BITSIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [BITSIZE-1:0] inflight_pc_q, inflight_pc_d;
    logic               inflight_q, inflight_d;

    logic issue, push, pop;

    // Credit covers buffered entries plus the outstanding read; same-cycle pops are not credited.
    always_comb begin
        issue = !rst && !bus.redirect &&
                ((count_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH));
        push  = inflight_q;
        pop   = (count_q != '0) && bus.inst_ready;
    end

    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = inflight_q;
        if (bus.redirect) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            inflight_d = 1'b0;
            fetch_pc_d = bus.redirect_pc;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + BITSIZE'(1);
            end else begin
                inflight_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            fetch_pc_q    <= '0;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (!rst && !bus.redirect && push) begin
            inst_mem_q[wr_ptr_q] <= bus.imem_rdata;
            pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

    always_comb begin
        bus.imem_req   = issue;
        bus.imem_addr  = fetch_pc_q[IMEM_AW-1:0];
        bus.inst_valid = (count_q != '0);
        bus.inst_out   = inst_mem_q[rd_ptr_q];
        bus.inst_pc    = pc_mem_q[rd_ptr_q];
        bus.fetch_pc   = fetch_pc_q;
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference model of the fetch stream.
module tb_ifetch_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    ifetch_queue_if #(.BITSIZE(64), .INSTSIZE(32), .IMEM_AW(8)) bus ();

    ifetch_queue #(
        .BITSIZE (64),
        .INSTSIZE(32),
        .DEPTH   (DEPTH),
        .IMEM_AW (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous instruction memory: data appears the cycle after the address.
    logic [31:0] mem [256];
    always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

    // Reference model: queue of buffered PCs, one pending read, next fetch PC.
    logic [63:0] mq [$];
    logic        m_inflight;
    logic [63:0] m_ipc;
    logic [63:0] m_fpc;
    logic [63:0] pops [$];

    int n_checks;
    int n_fail;
    int req_seen;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic [63:0] rpc, input logic rdy);
        logic        req_m;
        logic        pop_m;
        logic [63:0] hpc;
        @(negedge clk);
        rst             = r;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.inst_ready  = rdy;
        #1;
        req_m = !r && !rd && ((mq.size() + (m_inflight ? 1 : 0)) < DEPTH);
        check_eq("imem_req",   64'(bus.imem_req), 64'(req_m));
        check_eq("fetch_pc",   bus.fetch_pc, m_fpc);
        check_eq("imem_addr",  64'(bus.imem_addr), 64'(m_fpc[7:0]));
        check_eq("inst_valid", 64'(bus.inst_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            hpc = mq[0];
            check_eq("inst_pc",  bus.inst_pc, hpc);
            check_eq("inst_out", 64'(bus.inst_out), 64'(mem[hpc[7:0]]));
        end
        if (bus.imem_req) req_seen++;
        if (bus.inst_valid && rdy) pops.push_back(bus.inst_pc);
        pop_m = (mq.size() != 0) && rdy;
        if (r) begin
            mq.delete();
            m_inflight = 1'b0;
            m_fpc      = '0;
        end else if (rd) begin
            mq.delete();
            m_inflight = 1'b0;
            m_fpc      = rpc;
        end else begin
            if (pop_m) void'(mq.pop_front());
            if (m_inflight) begin
                check_eq("no_overflow", 64'(mq.size() >= DEPTH), 64'(0));
                mq.push_back(m_ipc);
            end
            if (req_m) begin
                m_inflight = 1'b1;
                m_ipc      = m_fpc;
                m_fpc      = m_fpc + 64'd1;
            end else begin
                m_inflight = 1'b0;
            end
        end
    endtask

    initial begin
        int          first_valid;
        int          bad;
        logic [63:0] rpc;
        n_checks = 0;
        n_fail   = 0;
        req_seen = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready  = 1'b0;
        mq.delete();
        m_inflight = 1'b0;
        m_ipc      = '0;
        m_fpc      = '0;
        repeat (2) @(posedge clk);

        // Streaming from reset with decode always ready.
        step(1'b1, 1'b0, '0, 1'b1);
        first_valid = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            if (bus.inst_valid && first_valid < 0) first_valid = i;
        end
        check_eq("first_valid_cycle", 64'(first_valid), 64'(2));
        check_eq("stream_pops", 64'(pops.size()), 64'(10));

        // Decode stalled from reset: exactly DEPTH requests, then drain.
        step(1'b1, 1'b0, '0, 1'b0);
        req_seen = 0;
        repeat (8) step(1'b0, 1'b0, '0, 1'b0);
        check_eq("stall_req_count", 64'(req_seen), 64'(DEPTH));
        pops.delete();
        repeat (8) step(1'b0, 1'b0, '0, 1'b1);
        check_eq("drain_first_pc", pops[0], 64'd0);
        check_eq("drain_fourth_pc", pops[3], 64'd3);

        // FIFO holds pcs 3..5 with pc 6 in flight, then redirect to 0x10.
        step(1'b0, 1'b1, 64'd3, 1'b0);
        repeat (4) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 64'h10, 1'b0);
        pops.delete();
        step(1'b0, 1'b0, '0, 1'b1);
        check_eq("redir_addr", 64'(bus.imem_addr), 64'h10);
        repeat (10) step(1'b0, 1'b0, '0, 1'b1);
        bad = 0;
        foreach (pops[i]) if (pops[i] >= 64'd3 && pops[i] <= 64'd6) bad++;
        check_eq("no_stale_pc", 64'(bad), 64'(0));
        check_eq("redir_first_pc", pops[0], 64'h10);

        // Ready toggling: no loss or duplication.
        pops.delete();
        for (int i = 0; i < 24; i++) step(1'b0, 1'b0, '0, 1'(i % 2));
        bad = 0;
        for (int i = 1; i < pops.size(); i++) if (pops[i] != pops[i-1] + 64'd1) bad++;
        check_eq("toggle_consecutive", 64'(bad), 64'(0));

        // PC wrap at all-ones.
        step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        pops.delete();
        repeat (6) step(1'b0, 1'b0, '0, 1'b1);
        check_eq("wrap_pc0", pops[0], 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("wrap_pc1", pops[1], 64'd0);

        // Reset mid-stream wins over a simultaneous redirect.
        step(1'b1, 1'b1, 64'h55, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        check_eq("rst_valid", 64'(bus.inst_valid), 64'(0));
        check_eq("rst_fetch_pc", bus.fetch_pc, 64'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) rpc = {$urandom(), $urandom()};
            else rpc = 64'hFFFF_FFFF_FFFF_FFFC + 64'($urandom_range(0, 7));
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 99) < 3), rpc,
                 1'($urandom_range(0, 99) < 65));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
